syn_gpu_mulbry_arb: RTL

//  Shares the GPU math units (mul, div, rand) between two requesters: the GPU core (CORE) and
//  the anti-aliaser (AA). One operation in flight at a time; round-robin grant on contention.

---
 rtl/syn_gpu_mulbry_arb.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/syn_gpu_mulbry_arb.sv
// Two-requester arbiter (CORE, AA) sharing the mul/div/rand units, one operation in flight.
// Optional WAIT watchdog enabled by defining SYN_GPU_MULBRY_ARB_TIMEOUT_EN.
module syn_gpu_mulbry_arb #(
  parameter int DATA_W      = 16,
  parameter int RES_W       = 2*DATA_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk_ir,
  input  logic               rst_ir,
  input  logic               core_req_i,
  input  logic [1:0]         core_op_i,
  input  logic [DATA_W-1:0]  core_a_i,
  input  logic [DATA_W-1:0]  core_b_i,
  output logic               core_gnt_o,
  output logic               core_res_vld_o,
  output logic [RES_W-1:0]   core_res_o,
  input  logic               aa_req_i,
  input  logic [1:0]         aa_op_i,
  input  logic [DATA_W-1:0]  aa_a_i,
  input  logic [DATA_W-1:0]  aa_b_i,
  output logic               aa_gnt_o,
  output logic               aa_res_vld_o,
  output logic [RES_W-1:0]   aa_res_o,
  output logic [2:0]         unit_start_o,
  output logic [DATA_W-1:0]  unit_a_o,
  output logic [DATA_W-1:0]  unit_b_o,
  input  logic [2:0]         unit_done_i,
  input  logic [3*RES_W-1:0] unit_res_i,
  output logic               busy_o,
  output logic               err_o
);

  if (TIMEOUT_CYC < 1 || RES_W < 2*DATA_W) begin : g_bad_cfg
    $error("syn_gpu_mulbry_arb: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_AA   = 1'b1;
  localparam logic [1:0] OP_RSV = 2'b11;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_gnt_q, last_gnt_d;
  logic [1:0]         op_q, op_d;
  logic [DATA_W-1:0]  ua_q, ua_d, ub_q, ub_d;
  logic [2:0]         start_q, start_d;
  logic               core_gnt_q, core_gnt_d, aa_gnt_q, aa_gnt_d;
  logic               core_vld_q, core_vld_d, aa_vld_q, aa_vld_d;
  logic [RES_W-1:0]   core_res_q, core_res_d, aa_res_q, aa_res_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

`ifdef SYN_GPU_MULBRY_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  function automatic logic [2:0] onehot(input logic [1:0] op);
    case (op)
      2'b00:   onehot = 3'b001;
      2'b01:   onehot = 3'b010;
      2'b10:   onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  logic             pick_aa;
  logic [1:0]       pick_op;
  logic             sel_done;
  logic [RES_W-1:0] sel_res;

  // Tie goes to whoever was not served last; a lone requester always wins.
  assign pick_aa  = aa_req_i && (!core_req_i || (last_gnt_q == OWN_CORE));
  assign pick_op  = pick_aa ? aa_op_i : core_op_i;
  assign sel_done = |(unit_done_i & onehot(op_q));

  always_comb begin
    sel_res = '0;
    case (op_q)
      2'b00:   sel_res = unit_res_i[0*RES_W +: RES_W];
      2'b01:   sel_res = unit_res_i[1*RES_W +: RES_W];
      2'b10:   sel_res = unit_res_i[2*RES_W +: RES_W];
      default: sel_res = '0;
    endcase
  end

  // Result delivery shared by every path into RESP.
  task automatic deliver(input logic [RES_W-1:0] r);
    state_d = S_RESP;
    ua_d    = '0;
    ub_d    = '0;
    if (owner_q == OWN_AA) begin
      aa_vld_d = 1'b1;
      aa_res_d = r;
    end else begin
      core_vld_d = 1'b1;
      core_res_d = r;
    end
  endtask

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    op_d       = op_q;
    ua_d       = ua_q;
    ub_d       = ub_q;
    start_d    = 3'b000;
    core_gnt_d = 1'b0;
    aa_gnt_d   = 1'b0;
    core_vld_d = 1'b0;
    aa_vld_d   = 1'b0;
    core_res_d = core_res_q;
    aa_res_d   = aa_res_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
`ifdef SYN_GPU_MULBRY_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (core_req_i || aa_req_i) begin
          state_d    = S_ISSUE;
          owner_d    = pick_aa ? OWN_AA : OWN_CORE;
          op_d       = pick_op;
          ua_d       = pick_aa ? aa_a_i : core_a_i;
          ub_d       = pick_aa ? aa_b_i : core_b_i;
          start_d    = onehot(pick_op);
          core_gnt_d = !pick_aa;
          aa_gnt_d   = pick_aa;
          busy_d     = 1'b1;
          err_d      = (pick_op == OP_RSV);
        end
      end
      S_ISSUE: begin
        if (op_q == OP_RSV) begin
          deliver('0);
        end else begin
          state_d = S_WAIT;
`ifdef SYN_GPU_MULBRY_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (sel_done) begin
          deliver(sel_res);
`ifdef SYN_GPU_MULBRY_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          deliver('0);
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      S_RESP: begin
        state_d    = S_IDLE;
        last_gnt_d = owner_q;
        busy_d     = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ir or posedge rst_ir) begin
    if (rst_ir) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_CORE;
      last_gnt_q <= OWN_AA;
      op_q       <= '0;
      ua_q       <= '0;
      ub_q       <= '0;
      start_q    <= '0;
      core_gnt_q <= 1'b0;
      aa_gnt_q   <= 1'b0;
      core_vld_q <= 1'b0;
      aa_vld_q   <= 1'b0;
      core_res_q <= '0;
      aa_res_q   <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef SYN_GPU_MULBRY_ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      op_q       <= op_d;
      ua_q       <= ua_d;
      ub_q       <= ub_d;
      start_q    <= start_d;
      core_gnt_q <= core_gnt_d;
      aa_gnt_q   <= aa_gnt_d;
      core_vld_q <= core_vld_d;
      aa_vld_q   <= aa_vld_d;
      core_res_q <= core_res_d;
      aa_res_q   <= aa_res_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
`ifdef SYN_GPU_MULBRY_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign core_gnt_o     = core_gnt_q;
  assign aa_gnt_o       = aa_gnt_q;
  assign core_res_vld_o = core_vld_q;
  assign aa_res_vld_o   = aa_vld_q;
  assign core_res_o     = core_res_q;
  assign aa_res_o       = aa_res_q;
  assign unit_start_o   = start_q;
  assign unit_a_o       = ua_q;
  assign unit_b_o       = ub_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;

endmodule
